dmem_responder: RTL

- Multi-cycle data-memory responder: the target end of the pipeline core's M-stage data interface (memwrite, address, writedata, readdata).
- Accepts one word load or store at a time and holds the pipeline with a stall output for a configurable access latency.
- Returns load data registered in a single completion cycle.
- Sits beside the core in the top-level SoC. Its stall feeds the core's hazard unit, which freezes F/D/E/M while stall=1.

---
 rtl/dmem_if.sv | 20 ++
 rtl/dmem_responder.sv | 99 +++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Core M-stage data-memory bus: request from the core, response and stall from the responder.
interface dmem_if;
  logic        memen;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        err;

  modport master (
    output memen, memwrite, addr, writedata,
    input  readdata, stall, err
  );

  modport slave (
    input  memen, memwrite, addr, writedata,
    output readdata, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: holds the core with stall for LATENCY+1 cycles per access,
// then completes in a single DONE cycle with registered load data and a misalignment pulse.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            req_write_q;
  logic [AW-1:0]   req_idx_q;
  logic            req_mis_q;
  logic [31:0]     req_wdata_q;
  logic [31:0]     readdata_q;
  logic            err_q;
  logic            stall;
  logic            capture;
  logic            access;
  logic [31:0]     mem [DEPTH];

  // Address bits above the word index wrap silently.
  logic unused_addr;
  assign unused_addr = ^bus.addr[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall = bus.memen;
        if (bus.memen) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        stall = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StDone;
        end
      end
      // The same instruction is still presented here, so memen must not retrigger.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      req_write_q <= 1'b0;
      req_idx_q   <= '0;
      req_mis_q   <= 1'b0;
      req_wdata_q <= 32'd0;
      readdata_q  <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        req_write_q <= bus.memwrite;
        req_idx_q   <= bus.addr[AW+1:2];
        req_mis_q   <= (bus.addr[1:0] != 2'b00);
        req_wdata_q <= bus.writedata;
      end
      err_q <= access & req_mis_q;
      if (access && !req_write_q) begin
        readdata_q <= req_mis_q ? 32'd0 : mem[req_idx_q];
      end
    end
  end

  // Array is never cleared; reset on the completing edge cancels the store.
  always_ff @(posedge clk) begin
    if (!rst && access && req_write_q && !req_mis_q) begin
      mem[req_idx_q] <= req_wdata_q;
    end
  end

  assign bus.stall    = stall;
  assign bus.readdata = readdata_q;
  assign bus.err      = err_q;

endmodule
